// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply / 32/32 divide unit with HI/LO registers
// One result bit per cycle over 32 CALC cycles, then one FIX cycle for sign correction.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] m;
  logic [63:0] acc;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic        neg_res;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  // op[0]=0 selects the signed variants, which iterate on magnitudes
  assign mag_a = (!op[0] && a[31]) ? -a : a;
  assign mag_b = (!op[0] && b[31]) ? -b : b;

  // multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);

  // divide: acc = {partial remainder, dividend bits shifting into quotient}
  assign rem_sh  = {acc[63:32], acc[31]};
  assign div_ge  = rem_sh >= {1'b0, m};
  assign div_sub = rem_sh[31:0] - m;

  assign neg_res = !op_r[0] && (a_r[31] ^ b_r[31]);
  assign prod    = neg_res ? -acc : acc;
  assign quot    = neg_res ? -acc[31:0] : acc[31:0];
  assign rem     = (!op_r[0] && a_r[31]) ? -acc[63:32] : acc[63:32];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      op_r        <= 2'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      m           <= 32'd0;
      acc         <= 64'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            cnt   <= 5'd0;
            m     <= op[1] ? mag_b : mag_a;
            acc   <= op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
            state <= CALC;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          if (op_r[1])
            acc <= div_ge ? {div_sub, acc[30:0], 1'b1} : {rem_sh[31:0], acc[30:0], 1'b0};
          else
            acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (op_r[1]) begin
            if (b_r == 32'd0) begin
              hi          <= a_r;
              lo          <= 32'hFFFF_FFFF;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem;
              lo <= quot;
            end
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz);
    longint sx, sy, q, r;
    logic [63:0] p;
    rdbz = 1'b0;
    if (o[0]) begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
    if (!o[1]) begin
      if (o[0]) p = {32'd0, x} * {32'd0, y};
      else      p = sx * sy;
      rhi = p[63:32];
      rlo = p[31:0];
    end else if (y == 32'd0) begin
      rhi  = x;
      rlo  = 32'hFFFF_FFFF;
      rdbz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      p = q;
      rlo = p[31:0];
      p = r;
      rhi = p[31:0];
    end
  endfunction

  // Issues an op from an IDLE or done cycle (#1 after an edge) and returns in its done cycle
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz);
    int edges;
    int bcnt;
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    checks++;
    if (hi !== hi0 || lo !== lo0) begin
      errors++;
      $display("FAIL %s hold: hi/lo %h/%h expected %h/%h", name, hi, lo, hi0, lo0);
    end
    edges = 1;
    bcnt  = busy ? 1 : 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy) bcnt++;
    end
    checks++;
    if (edges !== 34) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected 34", name, edges);
    end
    checks++;
    if (bcnt !== 33) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected 33", name, bcnt);
    end
    checks++;
    if (hi !== ehi || lo !== elo) begin
      errors++;
      $display("FAIL %s result: hi/lo %h/%h expected %h/%h", name, hi, lo, ehi, elo);
    end
    checks++;
    if (div_by_zero !== edbz) begin
      errors++;
      $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edbz);
    end
  endtask

  task automatic run_model_op(input string name, input logic [1:0] o, input logic [31:0] x,
                              input logic [31:0] y);
    logic [31:0] ehi, elo;
    logic edbz;
    model(o, x, y, ehi, elo, edbz);
    run_op(name, o, x, y, ehi, elo, edbz);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF_FFFF;
    op = 2'd1; a = 32'd5; b = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dbz %b%b%b expected 000", busy, done, div_by_zero);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: hi/lo %h/%h expected 0/0", hi, lo);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done/busy %b/%b expected 0/0", done, busy);
    end
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (div_by_zero !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL dbz_width: dbz/done %b/%b expected 0/0", div_by_zero, done);
    end
    checks++;
    if (hi !== 32'h64 || lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL idle_hold: hi/lo %h/%h expected 64/ffffffff", hi, lo);
    end
    run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_by0_signed", 2'b10, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_busy_ignore();
    int n;
    op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd9; mthi = 1'b1; wdata = 32'h1234;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL busy_ignore: done=%b hi/lo %h/%h expected 1 ffffffff/ffffffeb", done, hi, lo);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_busy: got %b expected 0", busy);
    end
    mtlo = 1'b1; wdata = 32'h55;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'h55 || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mtlo: hi/lo %h/%h expected ffffffff/00000055", hi, lo);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_5A5A || lo !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL mthi_mtlo: hi/lo %h/%h expected a5a55a5a/a5a55a5a", hi, lo);
    end
  endtask

  task automatic test_start_wins();
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    run_op("start_wins", 2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0);
  endtask

  task automatic test_mid_reset();
    int seen;
    op = 2'b01; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b hi/lo %h/%h expected 0 0 0/0", busy, done, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: active cycles %0d expected 0", seen);
    end
    run_model_op("after_reset", 2'b01, $urandom, $urandom);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_model_op($sformatf("b2b_%0d", i), 2'(i), $urandom, $urandom_range(1, 1000));
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
        3: y = -($urandom_range(1, 20));
        default: ;
      endcase
      run_model_op($sformatf("rand_%0d", i), o, x, y);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_start_wins();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
